keypad_serial_tx: RTL
=====================

Name: keypad_serial_tx

Overview:
- Parametrised successor to the switch-keyboard sender.
- Encodes a 4-bit switch code to ASCII on each debounced button press and queues the character in an internal FIFO.
- Drains the FIFO through an integrated 8N1 serial transmitter.
- Adds hex mode, optional CR/LF appending, queued back-to-back presses and overflow reporting; the previous generation had a single-character hold/start handshake.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per serial bit (115200 baud at 100 MHz); legal range >= 2.
- FIFO_DEPTH, 8, character slots; power of two, >= 4.
- HEX_MODE, 0, 0: codes 10-14 invalid, 15 -> 'u'; 1: codes 10-15 -> 'A'-'F'.
- APPEND_NEWLINE, 0, 1: each accepted press also queues 0x0D then 0x0A.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  4  switch code; sw[0] = LSB; sampled on the press cycle.
- btn_deb  input  1  already-debounced button level; synchronous to sysclk.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  characters currently queued.
- overflow  output  1  one-cycle pulse when a press is dropped for lack of space.

Behaviour:
- Reset values: tx=1, busy=0, fifo_count=0, overflow=0; FIFO pointers=0; transmitter in IDLE; btn_deb edge register=0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous); the queued content is discarded.
- Press detection: press = btn_deb high while its registered copy from the previous cycle was low. A held button produces exactly one press.
- Encoding (combinational from sw):
  - 0-9 -> 0x30-0x39.
  - HEX_MODE=1: 10-15 -> 0x41-0x46.
  - HEX_MODE=0: 15 -> 0x75; 10-14 invalid.
  - An invalid code on a press does nothing: no push, no overflow.
- Push rule: a valid press needs N free slots (N=1, or 3 if APPEND_NEWLINE).
  - If free < N: nothing is written, and overflow pulses high for the cycle after the press.
  - Otherwise the character is written in the press cycle, and fifo_count reflects it next cycle.
  - With APPEND_NEWLINE: CR and LF are written in the following two cycles. Presses arriving during those two cycles are ignored, with no overflow pulse.
- Pop: the transmitter pops when it is in IDLE and the FIFO is non-empty. A push and a pop in the same cycle are both honoured, and fifo_count is unchanged.
- Transmitter FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. On a pop, latch the byte and enter START the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB-first, each CLKS_PER_BIT cycles; 3-bit index, 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. IDLE lasts one cycle between frames when data is queued, so back-to-back frame starts are 10*CLKS_PER_BIT+1 cycles apart.
- Latency: the start bit (tx falls) appears 2 cycles after the press cycle when the FIFO is empty and the transmitter is idle.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps; width $clog2(CLKS_PER_BIT).
- FIFO pointers: $clog2(FIFO_DEPTH) bits, wrapping naturally. fifo_count saturates at FIFO_DEPTH; the full state is distinguished from empty by the count.
- busy = (state != IDLE) || (fifo_count != 0).

Decomposition:
- Package keypad_pkg: ASCII constants (ASCII_0, ASCII_A, ASCII_U, ASCII_CR, ASCII_LF) and the tx state enum (IDLE, START, DATA, STOP).
- One sub-module: uart_tx_8n1.
  - Parameter: CLKS_PER_BIT.
  - Ports: sysclk, rst, data[7:0], load, tx, ready. ready = in IDLE.
- Encoder, edge detector and FIFO stay in the top module.

Test Plan:
- CLKS_PER_BIT=4, sw=4'b0101, one press -> tx falls 2 cycles later; frame bits 0,1,0,1,0,1,1,0,0,1 (0x35 LSB-first), each 4 cycles; busy drops after the stop bit.
- HEX_MODE=0, sw=4'b1100 press -> no frame, fifo_count=0, overflow stays 0. HEX_MODE=1, same press -> 0x43 ('C') transmitted.
- FIFO_DEPTH=4: 6 presses on consecutive edges while the first frame is still sending -> first 5 accepted (1 in flight + 4 queued); the 6th pulses overflow; exactly 5 frames follow, in order.
- APPEND_NEWLINE=1, sw=0 -> frames 0x30, 0x0D, 0x0A back-to-back, each start 10*CLKS_PER_BIT+1 cycles apart.
- Assert rst during the DATA state of a frame -> tx=1 in the same cycle, fifo_count=0; after release, tx stays high with no residual frame.
- btn_deb held high for 1000 cycles -> exactly one frame.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, transmitter state type and key-code encoder for the keypad sender.
package keypad_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_U  = 8'h75;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Returns {valid, character}; codes with no glyph come back as all zeros.
  function automatic logic [8:0] encode_key(input logic [3:0] code, input logic hex_mode);
    if (code < 4'd10)
      return {1'b1, ASCII_0 + {4'd0, code}};
    else if (hex_mode)
      return {1'b1, ASCII_A + {4'd0, code} - 8'd10};
    else if (code == 4'hF)
      return {1'b1, ASCII_U};
    else
      return 9'd0;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB-first, one stop bit.
module uart_tx_8n1
  import keypad_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (clk_cnt == CNT_MAX);
  assign ready   = (state == IDLE);

  // tx is registered so the line level changes on the same edge as the state.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      clk_cnt <= (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= data;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_serial_tx.sv
// Keypad sender: press edge detect, ASCII encode, character FIFO and serial drain.
module keypad_serial_tx
  import keypad_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int FIFO_DEPTH     = 8,
  parameter int HEX_MODE       = 0,
  parameter int APPEND_NEWLINE = 0
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic [3:0]                    sw,
  input  logic                          btn_deb,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] NEED  = (APPEND_NEWLINE != 0) ? (PW+1)'(3) : (PW+1)'(1);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  logic          btn_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    nl_pend;
  logic          press;
  logic          key_valid;
  logic [7:0]    key_char;
  logic [PW:0]   free;
  logic          push;
  logic          pop;
  logic [7:0]    push_char;
  logic          ready;

  assign press                 = btn_deb & ~btn_q;
  assign {key_valid, key_char} = encode_key(sw, HEX_MODE != 0);
  assign free                  = DEPTH - fifo_count;
  assign pop                   = ready && (fifo_count != '0);
  assign busy                  = !ready || (fifo_count != '0);

  // While CR/LF are still owed, the slots reserved at the press are filled and new presses are ignored.
  always_comb begin
    push      = 1'b0;
    push_char = key_char;
    if (nl_pend == 2'd2) begin
      push      = 1'b1;
      push_char = ASCII_CR;
    end else if (nl_pend == 2'd1) begin
      push      = 1'b1;
      push_char = ASCII_LF;
    end else if (press && key_valid && free >= NEED) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      btn_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      nl_pend    <= '0;
    end else begin
      btn_q    <= btn_deb;
      overflow <= press && key_valid && (nl_pend == 2'd0) && (free < NEED);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (nl_pend != 2'd0)
        nl_pend <= nl_pend - 2'd1;
      else if (push && APPEND_NEWLINE != 0)
        nl_pend <= 2'd2;
    end
  end

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .sysclk (sysclk),
    .rst    (rst),
    .data   (mem[rd_ptr]),
    .load   (pop),
    .tx     (tx),
    .ready  (ready)
  );

endmodule
